// File: rtl/fpd_rr_scheduler.sv
// Round-robin scheduler sharing one multi-cycle FP divider among 2**ID_W requesters.
// A watchdog converts a hung divide into an error response carrying a quiet NaN.
module fpd_rr_scheduler #(
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned NUM_REQ = 1 << ID_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    div_start,
    output logic [31:0]             div_a,
    output logic [31:0]             div_b,
    input  logic                    div_done,
    input  logic [31:0]             div_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);
    localparam int unsigned OFS_W  = ID_W + 5;
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic              div_start_q, div_start_d;
    logic [DATA_W-1:0] div_a_q, div_a_d;
    logic [DATA_W-1:0] div_b_q, div_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   scan_idx;
    logic [OFS_W-1:0]  win_ofs;

    // First requesting index at or after ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        win_idx  = ptr_q;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = ptr_q + ID_W'(i);
            if (!found && req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
        win_ofs = {win_idx, 5'd0};
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        req_ack_d   = '0;
        div_start_d = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    div_a_d     = req_a[win_ofs +: DATA_W];
                    div_b_d     = req_b[win_ofs +: DATA_W];
                    rsp_id_d    = win_idx;
                    req_ack_d   = NUM_REQ'(1) << win_idx;
                    div_start_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the final watchdog cycle still delivers the real quotient.
                if (div_done) begin
                    rsp_data_d  = div_result;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = QNAN;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = rsp_id_q + ID_W'(1);
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            req_ack_q   <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            req_ack_q   <= req_ack_d;
            div_start_q <= div_start_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpd_rr_scheduler.sv
// Randomized bench for fpd_rr_scheduler: requester/divider models feed a transaction-level
// reference; expected responses are queued at issue and checked by an independent monitor.
module tb_fpd_rr_scheduler;

    localparam int unsigned TIMEOUT = 64;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ack;
    logic         div_start;
    logic [31:0]  div_a, div_b;
    logic         div_done;
    logic [31:0]  div_result;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_err, busy;

    fpd_rr_scheduler #(.ID_W(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_result(div_result), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus knobs
    int unsigned p_arm, p_withdraw, p_hang, p_ready;
    logic [3:0]  arm_mask;
    bit          fixed_ops;
    bit          mon_on;
    int          n_acc;

    typedef struct { int id; logic [31:0] a; logic [31:0] b; } grant_t;
    typedef struct { int id; logic [31:0] data; logic err; int cyc; } rsp_t;
    grant_t gq[$];
    rsp_t   rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    // Requesters: hold req until acked, may withdraw, re-arm later with fresh operands.
    always @(posedge clk) begin
        #1;
        if (rst) req = '0;
        else begin
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i]) req[i] = 1'b0;
                else if (req[i]) begin
                    if ($urandom_range(99) < p_withdraw) req[i] = 1'b0;
                end else if (arm_mask[i] && $urandom_range(99) < p_arm) begin
                    req[i] = 1'b1;
                    req_a[32*i +: 32] = fixed_ops ? 32'h4120_0000 : $urandom();
                    req_b[32*i +: 32] = fixed_ops ? 32'h4000_0000 : $urandom();
                end
            end
        end
        rsp_ready = ($urandom_range(99) < p_ready);
    end

    // Divider model: done pulse d cycles after start, or never (hang).
    int          dn_cnt = 0;
    logic [31:0] pend_res;
    always @(posedge clk) begin
        #1;
        div_done = 1'b0;
        if (dn_cnt > 0) begin
            dn_cnt--;
            if (dn_cnt == 0) begin
                div_done   = 1'b1;
                div_result = pend_res;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on && !rst && div_start) begin
            grant_t g;
            int d;
            logic [31:0] res;
            if (gq.size() == 0) chk("unexpected_div_start", 32'(div_start), 32'(0));
            else begin
                g = gq.pop_front();
                chk("div_a", div_a, g.a);
                chk("div_b", div_b, g.b);
                if (fixed_ops) begin
                    d = 25; res = 32'h40A0_0000;
                end else if ($urandom_range(99) < p_hang) begin
                    d = 0; res = QNAN;
                end else begin
                    case ($urandom_range(9))
                        0: d = 1;
                        1: d = TIMEOUT;
                        2: d = TIMEOUT - 1;
                        default: d = $urandom_range(TIMEOUT, 1);
                    endcase
                    res = $urandom();
                end
                dn_cnt   = d;
                pend_res = res;
                if (d == 0) rq.push_back('{g.id, QNAN, 1'b1, cyc + TIMEOUT + 1});
                else        rq.push_back('{g.id, res, 1'b0, cyc + d + 1});
            end
        end
    end

    // Monitor: grant prediction, busy, response ordering/content/latency/stability.
    logic [3:0] exp_ack = '0;
    bit   free   = 1'b1;
    int   ptr_m  = 0;
    bit   have_cur = 1'b0;
    rsp_t cur;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("req_ack", 32'(req_ack), 32'(exp_ack));
            chk("div_start", 32'(div_start), 32'(exp_ack != 4'd0));
            chk("busy", 32'(busy), 32'(!free));
            if (rsp_valid) begin
                if (!have_cur) begin
                    if (rq.size() == 0) chk("unexpected_rsp_valid", 32'(rsp_valid), 32'(0));
                    else begin
                        cur = rq.pop_front();
                        have_cur = 1'b1;
                        chk("rsp_id", 32'(rsp_id), 32'(cur.id));
                        chk("rsp_data", rsp_data, cur.data);
                        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                        chk("rsp_cycle", 32'(cyc), 32'(cur.cyc));
                    end
                end else begin
                    chk("rsp_id_stable", 32'(rsp_id), 32'(cur.id));
                    chk("rsp_data_stable", rsp_data, cur.data);
                    chk("rsp_err_stable", 32'(rsp_err), 32'(cur.err));
                end
            end else begin
                if (have_cur) begin
                    chk("rsp_valid_held", 32'(rsp_valid), 32'(1));
                    have_cur = 1'b0;
                end
                if (rq.size() > 0 && cyc > rq[0].cyc) begin
                    chk("rsp_late", 32'(rsp_valid), 32'(1));
                    void'(rq.pop_front());
                end
            end
            if (rst) begin
                gq.delete();
                rq.delete();
                have_cur = 1'b0;
                free     = 1'b1;
                ptr_m    = 0;
                exp_ack  = '0;
            end else begin
                exp_ack = '0;
                if (free && req != 4'd0) begin
                    int w;
                    w = winner(req, ptr_m);
                    exp_ack = 4'd1 << w;
                    gq.push_back('{w, req_a[32*w +: 32], req_b[32*w +: 32]});
                    free = 1'b0;
                end
                if (rsp_valid && rsp_ready && have_cur) begin
                    ptr_m    = (cur.id + 1) % 4;
                    free     = 1'b1;
                    have_cur = 1'b0;
                    n_acc++;
                end
            end
        end
    end

    task automatic wait_acc(input int n, input int budget);
        int target, t;
        target = n_acc + n;
        t = 0;
        while (n_acc < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        #2;
        chk("phase_complete", 32'(n_acc >= target), 32'(1));
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ack", 32'(req_ack), 32'(0));
        chk("rst_div_start", 32'(div_start), 32'(0));
        chk("rst_div_a", div_a, 32'(0));
        chk("rst_div_b", div_b, 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_rsp_data", rsp_data, 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int t;
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        div_done = 1'b0; div_result = '0; pend_res = '0;
        p_arm = 0; p_withdraw = 0; p_hang = 0; p_ready = 100;
        arm_mask = '0; fixed_ops = 1'b0; mon_on = 1'b0; n_acc = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check_reset_outputs();
        mon_on = 1'b1;

        // Single divide with known operands and quotient
        fixed_ops = 1'b1; arm_mask = 4'b0001; p_arm = 100;
        wait_acc(1, 200);
        fixed_ops = 1'b0;

        // All requesters held: strict rotation
        arm_mask = 4'b1111;
        wait_acc(8, 1500);

        // Sparse requesters exercise pointer wrap
        arm_mask = 4'b0101;
        wait_acc(6, 1500);

        // Hung divider -> watchdog error responses
        arm_mask = 4'b0001; p_hang = 100;
        wait_acc(2, 800);
        p_hang = 0;

        // Heavy backpressure on the response port
        arm_mask = 4'b1111; p_ready = 10;
        wait_acc(10, 4000);

        // Mixed random traffic
        p_ready = 60; p_arm = 30; p_withdraw = 5; p_hang = 8;
        wait_acc(120, 40000);

        // Reset mid-divide, then a stray done in IDLE
        p_hang = 100; p_withdraw = 0; p_arm = 100; arm_mask = 4'b0001;
        t = 0;
        while (!(busy && !div_start && req_ack == 4'd0 && !rsp_valid) && t < 2000) begin
            @(posedge clk); #2; t++;
        end
        chk("reach_wait", 32'(busy && !rsp_valid), 32'(1));
        arm_mask = 4'b0000;
        rst = 1'b1;
        dn_cnt = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        check_reset_outputs();
        dn_cnt = 2;
        repeat (6) begin
            @(posedge clk); #2;
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        end
        p_hang = 0; p_ready = 100; arm_mask = 4'b0010;
        wait_acc(1, 300);

        // Drain
        arm_mask = 4'b0000; p_withdraw = 100; p_ready = 100;
        repeat (200) @(posedge clk);
        #2;
        chk("drain_rsp_queue", 32'(rq.size()), 32'(0));
        chk("drain_idle", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpd_rr_scheduler.md
Name: fpd_rr_scheduler

Overview:
Shares one multi-cycle floating-point divider unit between NUM_REQ requesters. Arbitration is round-robin.
The block latches the winning requester's operands and pulses the divider's start. It then waits for the divider's done pulse and returns the tagged result over a valid/ready response port.
A watchdog turns a hung divide into an error response with a quiet NaN, so the scheduler never deadlocks.

Parameters:
ID_W, 2, requester-index width; NUM_REQ = 2**ID_W (default 4)
TIMEOUT, 64, max cycles in WAIT before error response (must be >= 2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request; held high until acked
req_a  in  32*NUM_REQ  dividend for requester i at bits [32i+31:32i]
req_b  in  32*NUM_REQ  divisor for requester i at bits [32i+31:32i]
req_ack  out  NUM_REQ  one-hot, one-cycle pulse: operands of that requester captured
div_start  out  1  one-cycle start pulse to divider
div_a  out  32  latched dividend, stable from ISSUE through WAIT
div_b  out  32  latched divisor, stable from ISSUE through WAIT
div_done  in  1  divider completion pulse (counted only in WAIT)
div_result  in  32  divider IEEE-754 result, valid with div_done
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  index of requester that owns the response
rsp_data  out  32  quotient, or 32'h7FC00000 on timeout
rsp_err  out  1  1 = watchdog timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-divide):
  - state=IDLE, round-robin pointer ptr=0, wait counter=0.
  - req_ack=0, div_start=0, div_a=div_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - Any divide in flight is abandoned; a later div_done is ignored in IDLE.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, the winner is the first set index scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - On that edge: latch winner's req_a/req_b into div_a/div_b, latch winner index into rsp_id, pulse req_ack[winner] for exactly the next cycle, go to ISSUE.
  - No req: stay in IDLE.
- ISSUE: div_start=1 for this one cycle; clear wait counter; go to WAIT.
- WAIT:
  - div_done=1: latch div_result into rsp_data, set rsp_err=0, go to RESP.
  - Else if counter == TIMEOUT-1: set rsp_data=32'h7FC00000, rsp_err=1, go to RESP.
  - Else: counter increments.
  - div_done wins if it coincides with the timeout cycle.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until a cycle with rsp_ready=1.
  - On the accepting edge: rsp_valid drops next cycle, ptr <= rsp_id+1 (mod NUM_REQ, wraps 3->0 at default), go to IDLE.
  - rsp_ready while rsp_valid=0 has no effect.
- Requesters: a requester may drop req before being acked (withdraw); only the req value at the IDLE decision edge matters.
- Ack-to-request ordering: req_ack is registered and appears one cycle after the decision. A requester re-arms only after seeing req_ack, so it is not granted twice for one request.
- Latency: min 4 cycles from req rise to rsp_valid when the divider returns done 1 cycle after start. Throughput: one divide in flight at a time.
- div_done outside WAIT is ignored. div_a/div_b keep their last value until the next grant.
- All outputs are registered; no combinational path from req/rsp_ready/div_done to any output.

Test Plan:
1. Reset, then req=4'b0001, req_a[31:0]=0x41200000 (10.0), req_b[31:0]=0x40000000 (2.0); divider model returns 0x40A00000 after 25 cycles -> req_ack=0001 pulse, div_start one cycle, rsp_valid with rsp_id=0, rsp_data=0x40A00000, rsp_err=0; ptr=1.
2. req=4'b1111 held, rsp_ready=1 always -> grant order 0,1,2,3,0; each req_ack one-hot, exactly one div_start per grant.
3. ptr=3 after a grant to 2, req=4'b0101 -> next grant 0 (wrap), then 2.
4. Divider never asserts done, TIMEOUT=64 -> RESP entered 64 cycles after div_start, rsp_data=0x7FC00000, rsp_err=1; next request served normally.
5. rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable, no new grant, no div_start; accept on cycle 11 -> IDLE.
6. rst=1 during WAIT, then div_done pulses -> all outputs 0, no rsp_valid; next req=4'b0010 granted to 1 with ptr starting from 0.
